// File: rtl/sc_node_fifo_stage.sv
// sc_node_fifo_stage: SmartConnect channel buffer, DEPTH-entry FIFO between a node and the switchboard.
// Optional SC_NODE_FIFO_STATS_EN adds stat_xfer_cnt / stat_hwm counters.
module sc_node_fifo_stage #(
   parameter int PAYLD_WIDTH   = 592,
   parameter int INFO_WIDTH    = 1,
   parameter int DEPTH         = 4,
   parameter int REQ_LOOKAHEAD = 1
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [PAYLD_WIDTH-1:0]        s_sc_payld,
   input  logic [INFO_WIDTH-1:0]         s_sc_info,
   input  logic                          s_sc_req,
   input  logic                          s_sc_send,
   output logic                          s_sc_recv,
   output logic [PAYLD_WIDTH-1:0]        m_sc_payld,
   output logic [INFO_WIDTH-1:0]         m_sc_info,
   output logic                          m_sc_req,
   output logic                          m_sc_send,
   input  logic                          m_sc_recv
`ifdef SC_NODE_FIFO_STATS_EN
   ,
   output logic [31:0]                   stat_xfer_cnt,
   output logic [$clog2(DEPTH):0]        stat_hwm
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int W  = PAYLD_WIDTH + INFO_WIDTH;
   logic [W-1:0]  r_mem [DEPTH];
   logic [W-1:0]  r_head, w_head_nxt;
   logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
   logic [CW-1:0] r_count, w_count_nxt;
   logic          r_recv, w_push, w_pop;
   // Next head is the freshly pushed beat when it lands exactly at the new read pointer.
   always_comb begin
      w_push      = s_sc_send && r_recv;
      w_pop       = (r_count != '0) && m_sc_recv;
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      w_rd_nxt    = r_rd_ptr + AW'(w_pop);
      w_head_nxt  = (w_count_nxt == '0) ? r_head :
                    (w_push && w_rd_nxt == r_wr_ptr) ? {s_sc_info, s_sc_payld} : r_mem[w_rd_nxt];
   end
   always_ff @(posedge aclk)
      if (w_push) r_mem[r_wr_ptr] <= {s_sc_info, s_sc_payld};
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_recv   <= 1'b0;
         r_head   <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_push);
         r_rd_ptr <= w_rd_nxt;
         r_count  <= w_count_nxt;
         r_recv   <= w_count_nxt < CW'(DEPTH);
         r_head   <= w_head_nxt;
      end
   assign s_sc_recv               = r_recv;
   assign m_sc_send               = r_count != '0;
   assign {m_sc_info, m_sc_payld} = r_head;
   assign m_sc_req                = (r_count != '0) || ((REQ_LOOKAHEAD != 0) && s_sc_req && aresetn);
`ifdef SC_NODE_FIFO_STATS_EN
   logic [31:0]   r_xfer_cnt;
   logic [CW-1:0] r_hwm;
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         r_xfer_cnt <= '0;
         r_hwm      <= '0;
      end else begin
         r_xfer_cnt <= r_xfer_cnt + 32'(w_pop);
         if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
      end
   assign stat_xfer_cnt = r_xfer_cnt;
   assign stat_hwm      = r_hwm;
`endif
endmodule

// File: tb/tb_sc_node_fifo_stage.sv
// tb_sc_node_fifo_stage: queue-model scoreboard for sc_node_fifo_stage, both REQ_LOOKAHEAD settings.
// Checks stat counters too when SC_NODE_FIFO_STATS_EN is defined.
module tb_sc_node_fifo_stage;
   localparam int PW = 16;
   localparam int D  = 4;
   logic          aclk = 0, aresetn = 1;
   logic [PW-1:0] s_sc_payld = 0;
   logic          s_sc_info = 0, s_sc_req = 0, s_sc_send = 0, m_sc_recv = 0;
   logic          s_sc_recv, m_sc_req, m_sc_send, m_sc_info;
   logic [PW-1:0] m_sc_payld;
   logic          b_recv, b_req, b_send, b_info;
   logic [PW-1:0] b_payld;
`ifdef SC_NODE_FIFO_STATS_EN
   logic [31:0]   xfer0, xfer1;
   logic [2:0]    hwm0, hwm1;
`endif
   always #5 aclk = ~aclk;

   sc_node_fifo_stage #(.PAYLD_WIDTH(PW), .INFO_WIDTH(1), .DEPTH(D), .REQ_LOOKAHEAD(1)) u0 (
      .aclk(aclk), .aresetn(aresetn), .s_sc_payld(s_sc_payld), .s_sc_info(s_sc_info),
      .s_sc_req(s_sc_req), .s_sc_send(s_sc_send), .s_sc_recv(s_sc_recv),
      .m_sc_payld(m_sc_payld), .m_sc_info(m_sc_info), .m_sc_req(m_sc_req),
      .m_sc_send(m_sc_send), .m_sc_recv(m_sc_recv)
`ifdef SC_NODE_FIFO_STATS_EN
      , .stat_xfer_cnt(xfer0), .stat_hwm(hwm0)
`endif
   );
   sc_node_fifo_stage #(.PAYLD_WIDTH(PW), .INFO_WIDTH(1), .DEPTH(D), .REQ_LOOKAHEAD(0)) u1 (
      .aclk(aclk), .aresetn(aresetn), .s_sc_payld(s_sc_payld), .s_sc_info(s_sc_info),
      .s_sc_req(s_sc_req), .s_sc_send(s_sc_send), .s_sc_recv(b_recv),
      .m_sc_payld(b_payld), .m_sc_info(b_info), .m_sc_req(b_req),
      .m_sc_send(b_send), .m_sc_recv(m_sc_recv)
`ifdef SC_NODE_FIFO_STATS_EN
      , .stat_xfer_cnt(xfer1), .stat_hwm(hwm1)
`endif
   );

   logic [PW:0] q[$];
   logic [PW:0] last = 0;
   bit          exp_recv = 0;
   int          n_chk = 0, n_pass = 0;
   int unsigned exp_xfer = 0, exp_hwm = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
   endtask

   // Model bookkeeping at the edge, then drive; an unaccepted beat is held stable.
   task automatic step(input bit snd, input logic [PW-1:0] pd, input bit inf, input bit rq, input bit mr);
      bit acc;
      @(posedge aclk);
      acc = s_sc_send && exp_recv;
      if (acc) q.push_back({s_sc_info, s_sc_payld});
      exp_recv = aresetn && (q.size() < D);
      if (aresetn && q.size() > exp_hwm) exp_hwm = q.size();
      #1;
      if (!s_sc_send || acc) begin
         s_sc_send  = snd;
         s_sc_payld = pd;
         s_sc_info  = inf;
      end
      s_sc_req  = rq;
      m_sc_recv = mr;
   endtask

   always @(negedge aclk) begin
      logic [PW:0] h;
      h = (q.size() != 0) ? q[0] : last;
      chk("send", m_sc_send, q.size() != 0);
      chk("payld", m_sc_payld, h[PW-1:0]);
      chk("info", m_sc_info, h[PW]);
      chk("recv", s_sc_recv, exp_recv);
      chk("req_la", m_sc_req, (q.size() != 0) || (s_sc_req && aresetn));
      chk("req_nola", b_req, q.size() != 0);
      chk("send_b", b_send, q.size() != 0);
      chk("payld_b", {b_info, b_payld}, h);
      chk("recv_b", b_recv, exp_recv);
`ifdef SC_NODE_FIFO_STATS_EN
      chk("xfer", xfer0, exp_xfer);
      chk("hwm", hwm0, exp_hwm);
      chk("hwm_b", hwm1, exp_hwm);
`endif
      if (q.size() != 0 && m_sc_recv) begin
         last = q.pop_front();
         exp_xfer++;
      end
   end

   initial begin
      #1 aresetn = 0;
      s_sc_req = 1;
      repeat (3) step(0, 0, 0, 1, 0);
      aresetn = 1;
      step(0, 0, 0, 0, 0);
      step(1, 16'h5A, 1, 1, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      for (int i = 1; i <= 5; i++) step(1, PW'(i), 1'(i), 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      repeat (7) step(0, 0, 0, 0, 1);
      step(1, 16'h100, 0, 0, 0);
      step(1, 16'h101, 1, 0, 0);
      for (int i = 0; i < 10; i++) step(1, PW'(16'h200 + i), 1'(i), 1, 1);
      repeat (4) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 400; i++)
         step(($urandom % 4) != 0, PW'($urandom), 1'($urandom), 1'($urandom), ($urandom % 3) != 0);
      repeat (6) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, PW'(16'hA0 + i), 0, 0, 0);
      step(0, 0, 0, 0, 0);
      #2;
      s_sc_req = 1;
      aresetn  = 0;
      #1;
      chk("rst_send", m_sc_send, 0);
      chk("rst_recv", s_sc_recv, 0);
      chk("rst_req", m_sc_req, 0);
      chk("rst_payld", m_sc_payld, 0);
`ifdef SC_NODE_FIFO_STATS_EN
      chk("rst_xfer", xfer0, 0);
      chk("rst_hwm", hwm0, 0);
`endif
      q.delete();
      last = 0; exp_recv = 0; exp_xfer = 0; exp_hwm = 0;
      s_sc_send = 0;
      repeat (2) step(0, 0, 0, 1, 1);
      aresetn = 1;
      for (int i = 0; i < 100; i++)
         step(($urandom % 2) != 0, PW'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4) == 0);
      repeat (8) step(0, 0, 0, 0, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
